// File: rtl/producto_bcd.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) that follows
// the shift-add multiplier and holds the packed BCD product for the display driver.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for a rising edge of ready == DONE_CODE
//   CONV  | add-3 / shift one product bit per cycle, IN_W cycles total
module producto_bcd #(
    parameter int          IN_W      = 17,
    parameter int          DIGITS    = 6,
    parameter logic [2:0]  DONE_CODE = 3'b100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            ready,
    input  logic [IN_W-1:0]       Producto,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  valid,
    output logic                  busy
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_W + 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t          state, state_next;
    logic            done_q;
    logic            trig;
    logic [IN_W-1:0] bin_q, bin_next;
    logic [BW-1:0]   work_q, work_next, work_adj, work_shift, bcd_next;
    logic [CW-1:0]   cnt_q, cnt_next;
    logic            valid_next, busy_next;

    // Only a rising edge of the done condition starts a conversion.
    assign trig = (ready == DONE_CODE) && !done_q;

    always_comb begin
        work_adj = work_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign work_shift = {work_adj[BW-2:0], bin_q[IN_W-1]};

    always_comb begin
        state_next = state;
        bin_next   = bin_q;
        work_next  = work_q;
        cnt_next   = cnt_q;
        bcd_next   = bcd;
        valid_next = 1'b0;
        busy_next  = busy;
        case (state)
            IDLE: begin
                if (trig) begin
                    bin_next   = Producto;
                    work_next  = '0;
                    cnt_next   = CW'(IN_W);
                    busy_next  = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                work_next = work_shift;
                bin_next  = {bin_q[IN_W-2:0], 1'b0};
                cnt_next  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_next   = work_shift;
                    valid_next = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            done_q <= 1'b0;
            bin_q  <= '0;
            work_q <= '0;
            cnt_q  <= '0;
            bcd    <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= (ready == DONE_CODE);
            bin_q  <= bin_next;
            work_q <= work_next;
            cnt_q  <= cnt_next;
            bcd    <= bcd_next;
            valid  <= valid_next;
            busy   <= busy_next;
        end
    end

endmodule

// File: tb/tb_producto_bcd.sv
// Self-checking bench for producto_bcd: directed scenarios plus random ready/Producto
// traffic, compared every cycle against a timing-level reference model.
module tb_producto_bcd;

    localparam int         IN_W  = 17;
    localparam int         DIG   = 6;
    localparam logic [2:0] DONE  = 3'b100;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [2:0]      ready = 3'b000;
    logic [IN_W-1:0] Producto = '0;
    logic [4*DIG-1:0] bcd;
    logic            valid, busy;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    producto_bcd #(.IN_W(IN_W), .DIGITS(DIG), .DONE_CODE(DONE)) dut (
        .clk(clk), .rst(rst), .ready(ready), .Producto(Producto),
        .bcd(bcd), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [4*DIG-1:0] to_bcd(input int v);
        logic [4*DIG-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIG; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic digits_ok(input logic [4*DIG-1:0] b);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIG; i++) if (b[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    // Reference model: a conversion is just "result appears IN_W cycles after capture".
    logic            m_done  = 1'b0;
    logic            m_busy  = 1'b0;
    logic            m_valid = 1'b0;
    logic [4*DIG-1:0] m_bcd  = '0;
    int              m_left  = 0;
    int              m_val   = 0;

    always @(posedge clk) begin
        if (!rst) begin
            m_done = 1'b0; m_busy = 1'b0; m_valid = 1'b0; m_bcd = '0; m_left = 0;
        end else begin
            m_valid = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_bcd   = to_bcd(m_val);
                    m_valid = 1'b1;
                    m_busy  = 1'b0;
                end
            end else if (ready == DONE && !m_done) begin
                m_val  = int'(Producto);
                m_left = IN_W;
                m_busy = 1'b1;
            end
            m_done = (ready == DONE);
        end
    end

    always @(negedge clk) begin
        check("busy",   32'(busy),  32'(m_busy));
        check("valid",  32'(valid), 32'(m_valid));
        check("bcd",    32'(bcd),   32'(m_bcd));
        check("digits", 32'(digits_ok(bcd)), 32'd1);
        if (valid) pulses++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic convert(input int v, input int hold, input logic [23:0] exp, input string tag);
        int p0;
        p0 = pulses;
        Producto = IN_W'(v);
        ready = DONE;
        cycles(hold);
        ready = 3'b000;
        cycles(IN_W + 3 - hold);
        check({tag, "_bcd"}, 32'(bcd), 32'(exp));
        check({tag, "_pulses"}, 32'(pulses - p0), 32'd1);
    endtask

    initial begin
        int p0;
        cycles(3);
        check("rst_bcd",   32'(bcd),   32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        rst = 1'b1;
        cycles(2);

        convert(437,    2, 24'h000437, "p437");
        convert(0,      1, 24'h000000, "zero");
        convert(65025,  3, 24'h065025, "p65025");
        convert(131071, 4, 24'h131071, "max");

        // Long-held done condition gives one conversion; a fresh rising edge gives another.
        p0 = pulses;
        Producto = IN_W'(777);
        ready = DONE;
        cycles(60);
        check("hold_pulses", 32'(pulses - p0), 32'd1);
        check("hold_bcd", 32'(bcd), 32'h000777);
        ready = 3'b000;
        cycles(2);
        convert(1234, 2, 24'h001234, "p1234");

        // Retrigger while busy is dropped.
        p0 = pulses;
        Producto = IN_W'(437);
        ready = DONE;
        cycles(1);
        ready = 3'b000;
        cycles(4);
        Producto = IN_W'(999);
        ready = DONE;
        cycles(1);
        ready = 3'b000;
        cycles(IN_W + 6);
        check("busytrig_pulses", 32'(pulses - p0), 32'd1);
        check("busytrig_bcd", 32'(bcd), 32'h000437);

        // Reset in the middle of a conversion discards it.
        p0 = pulses;
        Producto = IN_W'(4321);
        ready = DONE;
        cycles(1);
        ready = 3'b000;
        cycles(7);
        rst = 1'b0;
        ready = DONE;
        Producto = IN_W'(437);
        cycles(1);
        check("midrst_busy",  32'(busy),  32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_bcd",   32'(bcd),   32'd0);
        cycles(2);
        rst = 1'b1;
        cycles(1);
        check("restart_busy", 32'(busy), 32'd1);
        cycles(IN_W + 2);
        check("midrst_pulses", 32'(pulses - p0), 32'd1);
        check("restart_bcd", 32'(bcd), 32'h000437);
        ready = 3'b000;
        cycles(2);

        for (int it = 0; it < 60; it++) begin
            ready    = ($urandom_range(0, 1) == 1) ? DONE : 3'($urandom_range(0, 7));
            Producto = IN_W'($urandom_range(0, 131071));
            cycles($urandom_range(1, 25));
        end
        ready = 3'b000;
        cycles(IN_W + 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
